// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the UART receiver.
package uart_rx_fifo_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  // Smallest n with 2**n >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO with extra-MSB pointers for full/empty detection.
module uart_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_rd, do_wr;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_i & ~empty_o;
  // A read in the same cycle frees the slot, so a write while full still lands.
  assign do_wr   = wr_i & (~full_o | do_rd);
  assign drop_o  = wr_i & ~do_wr;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, error pulses and a buffered receive FIFO.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY_MODE    = 0,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 incoming_bit,
  input  logic                 read_data,
  input  logic                 clear_errors,
  output logic                 has_data,
  output logic [DATA_BITS-1:0] data_received,
  output logic                 fifo_full,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun
);

  localparam int unsigned CW = clog2(CLOCKS_PER_BIT);
  localparam int unsigned BW = clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_MID   = CW'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic                 sync1_q, sync2_q;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 wr_q, wr_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 bit_tick, ferr_now, par_x, par_bad;
  logic                 fifo_empty, fifo_drop;

  assign bit_tick = (cnt_q == BIT_LAST);
  assign ferr_now = ferr_q | ~sync2_q;
  assign par_x    = (^shift_q) ^ par_q;
  assign par_bad  = (PARITY_MODE == PARITY_ODD)  ? ~par_x :
                    (PARITY_MODE == PARITY_EVEN) ?  par_x : 1'b0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    ferr_d       = ferr_q;
    wr_d         = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        ferr_d = 1'b0;
        if (!sync2_q) state_d = START;
      end
      START: begin
        if (cnt_q == BIT_MID) begin
          cnt_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          par_d   = sync2_q;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_d  = '0;
          ferr_d = ferr_now;
          if (idx_q == STOP_LAST) begin
            // Frame error outranks parity; only a clean frame reaches the FIFO.
            idx_d        = '0;
            state_d      = IDLE;
            frame_err_d  = ferr_now;
            parity_err_d = ~ferr_now & par_bad;
            wr_d         = ~ferr_now & ~par_bad;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (fifo_drop)         overrun_d = 1'b1;
    else if (clear_errors) overrun_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      ferr_q       <= 1'b0;
      wr_q         <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= incoming_bit;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      ferr_q       <= ferr_d;
      wr_q         <= wr_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .wr_i    (wr_q),
    .wdata_i (shift_q),
    .rd_i    (read_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .drop_o  (fifo_drop),
    .rdata_o (data_received)
  );

  assign has_data     = ~fifo_empty;
  assign frame_error  = frame_err_q;
  assign parity_error = parity_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: three receivers (8N1, 8E1, 8N2) fed frames built from the framing rules.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  typedef enum int {KData = 0, KFerr = 1, KPerr = 2} kind_e;
  typedef struct {
    int          inst;
    kind_e       kind;
    logic [7:0]  data;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clear_errors;
  logic [2:0] line;
  logic [2:0] rd = '0;
  logic [2:0] auto_rd;
  logic [2:0] has_data, fifo_full, ferr, perr, ovr;
  logic [7:0] dout [3];

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_rx_fifo #(
      .CLOCKS_PER_BIT (CPB),
      .DATA_BITS      (8),
      .PARITY_MODE    ((g == 1) ? 2 : 0),
      .STOP_BITS      ((g == 2) ? 2 : 1),
      .FIFO_DEPTH     (4)
    ) u_dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .incoming_bit  (line[g]),
      .read_data     (rd[g]),
      .clear_errors  (clear_errors),
      .has_data      (has_data[g]),
      .data_received (dout[g]),
      .fifo_full     (fifo_full[g]),
      .frame_error   (ferr[g]),
      .parity_error  (perr[g]),
      .overrun       (ovr[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_event(input int inst, input kind_e kind, input logic [7:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected event: inst %0d kind %0d data 0x%0h, expected nothing",
               inst, kind, data);
    end else begin
      e = exp_q.pop_front();
      check("scoreboard {inst,kind,data}", {8'(inst), 8'(kind), data},
            {8'(e.inst), 8'(e.kind), e.data});
    end
  endtask

  // Monitor: error pulses and delivered words are matched against the queue in order.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset_n === 1'b1) begin
        if (ferr[i]) expect_event(i, KFerr, 8'h00);
        if (perr[i]) expect_event(i, KPerr, 8'h00);
        if (has_data[i] && auto_rd[i]) begin
          expect_event(i, KData, dout[i]);
          rd[i] = 1'b1;
        end else begin
          rd[i] = 1'b0;
        end
      end else begin
        rd[i] = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input int inst, input logic v, input int n);
    line[inst] = v;
    idle(n);
  endtask

  task automatic push(input int inst, input kind_e kind, input logic [7:0] data);
    exp_q.push_back('{inst: inst, kind: kind, data: (kind == KData) ? data : 8'h00});
  endtask

  // bad_stop: index of the stop bit driven low at its centre, or -1 for none.
  task automatic send_frame(input int inst, input logic [7:0] data, input int pmode,
                            input bit pbad, input int nstop, input int bad_stop);
    logic pbit;
    drive(inst, 1'b0, CPB);
    for (int b = 0; b < 8; b++) drive(inst, data[b], CPB);
    if (pmode != 0) begin
      pbit = (pmode == 2) ? ^data : ~^data;
      drive(inst, pbit ^ pbad, CPB);
    end
    for (int s = 0; s < nstop; s++) begin
      if (s == bad_stop) begin
        drive(inst, 1'b0, 9);
        drive(inst, 1'b1, CPB - 9);
      end else begin
        drive(inst, 1'b1, CPB);
      end
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(negedge clock);
      c++;
    end
    check("scoreboard drained within bound", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int rise;
    int inst, bad_stop;
    bit pbad;
    logic [7:0] data;

    line         = '1;
    clear_errors = 1'b0;
    auto_rd      = '1;
    reset_n      = 1'b0;
    idle(3);
    check("reset flags", {has_data, fifo_full, ferr, perr, ovr}, 0);
    for (int i = 0; i < 3; i++) check("reset data_received", dout[i], 0);
    reset_n = 1'b1;
    idle(5);

    // 8N1 0xAB: word lands near the end of the stop bit
    auto_rd[0] = 1'b0;
    push(0, KData, 8'hAB);
    rise = 0;
    fork
      send_frame(0, 8'hAB, 0, 1'b0, 1, -1);
      begin
        while (!has_data[0] && rise < 400) begin
          @(negedge clock);
          rise++;
        end
      end
    join
    check("8N1 has_data rise in stop-bit window", (rise >= 150 && rise <= 162), 1);
    check("8N1 data_received", dout[0], 8'hAB);
    auto_rd[0] = 1'b1;
    wait_drain();

    // 8E1 0x53 with wrong parity bit
    push(1, KPerr, 8'h00);
    send_frame(1, 8'h53, 2, 1'b1, 1, -1);
    idle(20);
    check("8E1 bad parity stores nothing", has_data[1], 0);
    wait_drain();

    // 8N2 0x3C with second stop bit low
    push(2, KFerr, 8'h00);
    send_frame(2, 8'h3C, 0, 1'b0, 2, 1);
    idle(20);
    check("8N2 bad stop stores nothing", has_data[2], 0);
    wait_drain();

    // 4-cycle low glitch on idle line
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 40);
    check("glitch leaves no data or flags", {has_data[0], ferr[0], perr[0], ovr[0]}, 0);
    push(0, KData, 8'h96);
    send_frame(0, 8'h96, 0, 1'b0, 1, -1);
    idle(4);
    wait_drain();

    // Fill FIFO without reads; fifth word overruns
    auto_rd[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) push(0, KData, 8'(k));
      send_frame(0, 8'(k), 0, 1'b0, 1, -1);
      idle(4);
    end
    idle(10);
    check("fifo_full after 5 frames", fifo_full[0], 1);
    check("overrun after 5 frames", ovr[0], 1);
    auto_rd[0] = 1'b1;
    wait_drain();
    idle(5);
    check("fifo_full after drain", fifo_full[0], 0);
    check("overrun sticky after drain", ovr[0], 1);
    clear_errors = 1'b1;
    idle(1);
    clear_errors = 1'b0;
    check("overrun cleared", ovr[0], 0);

    // Randomised frames across all three formats
    for (int n = 0; n < 18; n++) begin
      inst     = $urandom_range(0, 2);
      data     = 8'($urandom);
      pbad     = (inst == 1) && ($urandom_range(0, 2) == 0);
      bad_stop = ($urandom_range(0, 4) == 0) ? 0 : -1;
      if (inst == 2 && bad_stop < 0 && $urandom_range(0, 3) == 0) bad_stop = 1;
      if (bad_stop >= 0)  push(inst, KFerr, 8'h00);
      else if (pbad)      push(inst, KPerr, 8'h00);
      else                push(inst, KData, data);
      send_frame(inst, data, (inst == 1) ? 2 : 0, pbad, (inst == 2) ? 2 : 1, bad_stop);
      idle((bad_stop >= 0) ? 20 + $urandom_range(0, 8) : $urandom_range(0, 12));
    end
    wait_drain();
    check("no overrun after random frames", ovr, 0);

    // Reset during DATA of 0xFF, then a clean 0x5A
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, 3 * CPB);
    reset_n = 1'b0;
    idle(2);
    check("mid-frame reset flags", {has_data, fifo_full, ferr, perr, ovr}, 0);
    for (int i = 0; i < 3; i++) check("mid-frame reset data_received", dout[i], 0);
    reset_n = 1'b1;
    idle(8 * CPB);
    push(0, KData, 8'h5A);
    send_frame(0, 8'h5A, 0, 1'b0, 1, -1);
    idle(4);
    wait_drain();

    idle(10);
    check("scoreboard empty at end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLOCKS_PER_BIT, default 87, clock cycles per serial bit (10 MHz / 115200); legal range >= 4.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_MODE, default 0, parity type: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, received-word buffer depth; power of two, >= 2.
REQ-006 Port: clock, input, 1, the only clock; all logic is on its rising edge.
REQ-007 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-008 Port: incoming_bit, input, 1, asynchronous serial line; idles high.
REQ-009 Port: read_data, input, 1, pops the FIFO head on a cycle where has_data = 1.
REQ-010 Port: clear_errors, input, 1, clears overrun.
REQ-011 Port: has_data, output, 1, FIFO not empty.
REQ-012 Port: data_received, output, DATA_BITS, FIFO head word (first-word fall-through).
REQ-013 Port: fifo_full, output, 1, FIFO holds FIFO_DEPTH words.
REQ-014 Port: frame_error, output, 1, one-cycle pulse on a bad stop bit.
REQ-015 Port: parity_error, output, 1, one-cycle pulse on a parity mismatch.
REQ-016 Port: overrun, output, 1, sticky flag set when a good word is dropped because the FIFO is full.

Function
REQ-017 incoming_bit SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE -> START on a synchronized low; the bit counter is cleared.
REQ-020 START SHALL resample the line at count (CLOCKS_PER_BIT-1)/2.
- Line still low: go to DATA, counter restarts.
- Line high: glitch, return to IDLE with no flags.
REQ-021 DATA SHALL sample every CLOCKS_PER_BIT cycles, LSB first, DATA_BITS samples.
- Next state is PARITY if PARITY_MODE != 0, else STOP.
REQ-022 PARITY SHALL sample one bit and compare it with the XOR of the data bits.
- Odd mode: mismatch if XOR of data and parity bit = 0.
- Even mode: mismatch if that XOR = 1.
REQ-023 STOP SHALL sample STOP_BITS bits, one per CLOCKS_PER_BIT cycles.
- Any low sample marks a frame error.
REQ-024 After the final stop sample the FSM SHALL return to IDLE the next cycle, so a start bit may begin in the second half of the stop bit.
REQ-025 Error priority at frame end:
- Frame error: pulse frame_error, discard the word, no parity_error pulse.
- Else parity mismatch: pulse parity_error, discard the word.
- Else: write the word to the FIFO.
REQ-026 A FIFO write SHALL occur on the cycle after the final stop sample; has_data rises on the following cycle.
REQ-027 A write while full with no simultaneous read SHALL drop the word and set overrun; FIFO contents are unchanged.
REQ-028 A simultaneous read and write while full SHALL both succeed; overrun is not set.
REQ-029 read_data while empty SHALL be ignored with no pointer change.
REQ-030 Read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
- Full: MSBs differ and lower bits equal.
- Empty: pointers equal.
REQ-031 overrun SHALL clear on clear_errors; if set and clear coincide, set wins.
REQ-032 Data is unsigned; unused upper bits of the shift register SHALL never appear on data_received.

Reset
REQ-033 When reset_n = 0, asynchronously:
- FSM to IDLE; counters and pointers to 0; synchronizer flops to 1.
- has_data = 0, fifo_full = 0, frame_error = 0, parity_error = 0, overrun = 0.
- data_received = 0.
REQ-034 Reset mid-frame SHALL abandon the frame; after release, the next start bit is received normally.

Structure
REQ-035 A shared package SHALL hold:
- PARITY_NONE/ODD/EVEN constants.
- The FSM state typedef.
- A clog2 helper function.
REQ-036 The FIFO SHALL be one sub-module, uart_fifo, parametrised by WIDTH and DEPTH, with its own async active-low reset.

Verification (CLOCKS_PER_BIT = 16 unless stated)
REQ-037 8N1 frame with data 0xAB -> data_received = 0xAB, has_data = 1 one cycle after the write, no error pulses.
REQ-038 8E1 frame with data 0x53 and parity bit 1 (wrong) -> single parity_error pulse, has_data stays 0.
REQ-039 8N2 frame with data 0x3C and second stop bit low -> single frame_error pulse, nothing stored.
REQ-040 FIFO_DEPTH = 4, no reads, frames 0x00..0x04 -> fifo_full = 1, overrun = 1; reads return 0x00, 0x01, 0x02, 0x03; clear_errors clears overrun.
REQ-041 Low glitch of 4 cycles on an idle line -> FSM back in IDLE, no data, no flags.
REQ-042 reset_n pulsed low during DATA of frame 0xFF -> all outputs 0; the next frame 0x5A is received correctly.
